// File: rtl/led_display_pkg.sv
// Shared definitions for the LED row pattern generator: mode codes, lane layout
// of the packed row word and the controller state type.
package led_display_pkg;

  localparam logic [2:0] MODE_OFF        = 3'd0;
  localparam logic [2:0] MODE_SOLID      = 3'd1;
  localparam logic [2:0] MODE_SCAN_H     = 3'd2;
  localparam logic [2:0] MODE_SCAN_V     = 3'd3;
  localparam logic [2:0] MODE_CHECKER    = 3'd4;
  localparam logic [2:0] MODE_DEBUG_ADDR = 3'd7;

  localparam int LANE_TOP_RED   = 0;
  localparam int LANE_TOP_GREEN = 1;
  localparam int LANE_TOP_BLUE  = 2;
  localparam int LANE_BOT_RED   = 3;
  localparam int LANE_BOT_GREEN = 4;
  localparam int LANE_BOT_BLUE  = 5;
  localparam int NUM_LANES      = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRESENT,
    ST_FRAME_END
  } state_t;

  // Bit position of column 0 of a lane inside the packed row word.
  function automatic int lane_offset(input int lane, input int num_cols);
    return lane * num_cols;
  endfunction

endpackage

// File: rtl/led_effect_timer.sv
// Free-running divider that emits a one-cycle tick every EFFECT_TIMER cycles.
module led_effect_timer #(
  parameter int EFFECT_TIMER = 1_000_000
) (
  input  logic clk_in,
  input  logic n_reset_in,
  output logic tick
);

  localparam int CNT_W = (EFFECT_TIMER > 1) ? $clog2(EFFECT_TIMER) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(EFFECT_TIMER - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/led_pattern_gen_p.sv
// Row-pair pattern generator with a valid/ready row stream. Define
// LED_PATTERN_DEBUG_EN to enable the DEBUG_ADDR mode (code 7); otherwise it renders OFF.
module led_pattern_gen_p
  import led_display_pkg::*;
#(
  parameter int SYS_CLK_FREQ  = 100_000_000,
  parameter int NUM_COLS      = 64,
  parameter int NUM_ROW_PAIRS = 16,
  parameter int EFFECT_TIMER  = 1_000_000,
  localparam int ADDR_W       = $clog2(NUM_ROW_PAIRS)
) (
  input  logic                     clk_in,
  input  logic                     n_reset_in,
  input  logic [2:0]               colour_in,
  input  logic [2:0]               mode_in,
  output logic [6*NUM_COLS-1:0]    row_out,
  output logic                     row_valid_out,
  input  logic                     row_ready_in,
  output logic [ADDR_W-1:0]        row_address_out,
  output logic                     frame_start_out,
  output logic [2:0]               mode_active_out
);

  if (NUM_COLS < 8 || NUM_COLS > 128) begin : g_bad_cols
    $error("NUM_COLS must be in 8..128");
  end
  if (NUM_ROW_PAIRS < 2 || NUM_ROW_PAIRS > 32 || (NUM_ROW_PAIRS & (NUM_ROW_PAIRS - 1)) != 0) begin : g_bad_rows
    $error("NUM_ROW_PAIRS must be a power of two in 2..32");
  end
  if (SYS_CLK_FREQ <= 0 || EFFECT_TIMER < 1) begin : g_bad_timing
    $error("SYS_CLK_FREQ and EFFECT_TIMER must be positive");
  end

  localparam int COL_W = $clog2(NUM_COLS);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ROW_PAIRS - 1);
  localparam int OFF_TR = lane_offset(LANE_TOP_RED, NUM_COLS);
  localparam int OFF_TG = lane_offset(LANE_TOP_GREEN, NUM_COLS);
  localparam int OFF_TB = lane_offset(LANE_TOP_BLUE, NUM_COLS);
  localparam int OFF_BR = lane_offset(LANE_BOT_RED, NUM_COLS);
  localparam int OFF_BG = lane_offset(LANE_BOT_GREEN, NUM_COLS);
  localparam int OFF_BB = lane_offset(LANE_BOT_BLUE, NUM_COLS);

  state_t                  state, state_nx;
  logic [ADDR_W-1:0]       addr;
  logic [2:0]              mode_pending, mode_active;
  logic [COL_W-1:0]        col_pos;
  logic [ADDR_W-1:0]       row_pos;
  logic                    phase;
  logic                    tick, tick_pending;
  logic                    transfer, frame_edge;
  logic [6*NUM_COLS-1:0]   row, row_nx;
  logic [NUM_COLS-1:0]     top_mask, bot_mask;

  led_effect_timer #(.EFFECT_TIMER(EFFECT_TIMER)) u_timer (
    .clk_in     (clk_in),
    .n_reset_in (n_reset_in),
    .tick       (tick)
  );

  assign transfer   = (state == ST_PRESENT) && row_ready_in;
  assign frame_edge = (state == ST_IDLE) || (state == ST_FRAME_END);

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) state <= ST_IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      state_nx = ST_LOAD;
      ST_LOAD:      state_nx = ST_PRESENT;
      ST_PRESENT:   if (transfer) state_nx = (addr == LAST_ADDR) ? ST_FRAME_END : ST_LOAD;
      ST_FRAME_END: state_nx = ST_LOAD;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // Request is tracked continuously; it only takes effect at a frame boundary.
  always_ff @(posedge clk_in) begin
    mode_pending <= mode_in;
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      addr         <= '0;
      mode_active  <= MODE_OFF;
      col_pos      <= '0;
      row_pos      <= '0;
      phase        <= 1'b0;
      tick_pending <= 1'b0;
      row          <= '0;
    end else begin
      if (transfer) addr <= addr + 1'b1;
      if (frame_edge) begin
        mode_active <= mode_pending;
        if (mode_pending != mode_active) begin
          col_pos <= '0;
          row_pos <= '0;
          phase   <= 1'b0;
        end else if (tick_pending && state == ST_FRAME_END) begin
          col_pos <= (col_pos == LAST_COL) ? '0 : col_pos + 1'b1;
          row_pos <= (row_pos == LAST_ADDR) ? '0 : row_pos + 1'b1;
          phase   <= ~phase;
        end
      end
      // A fresh tick wins over consumption so it is never lost.
      if (tick)                        tick_pending <= 1'b1;
      else if (state == ST_FRAME_END)  tick_pending <= 1'b0;
      if (state == ST_LOAD) row <= row_nx;
    end
  end

  always_comb begin
    top_mask = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      case (mode_active)
        MODE_SOLID:   top_mask[c] = 1'b1;
        MODE_SCAN_H:  top_mask[c] = (col_pos == COL_W'(c));
        MODE_SCAN_V:  top_mask[c] = (addr == row_pos);
        MODE_CHECKER: top_mask[c] = c[0] ^ addr[0] ^ phase;
        default:      top_mask[c] = 1'b0;
      endcase
    end
    bot_mask = (mode_active == MODE_CHECKER) ? ~top_mask : top_mask;

    row_nx = '0;
    row_nx[OFF_TR +: NUM_COLS] = top_mask & {NUM_COLS{colour_in[0]}};
    row_nx[OFF_TG +: NUM_COLS] = top_mask & {NUM_COLS{colour_in[1]}};
    row_nx[OFF_TB +: NUM_COLS] = top_mask & {NUM_COLS{colour_in[2]}};
    row_nx[OFF_BR +: NUM_COLS] = bot_mask & {NUM_COLS{colour_in[0]}};
    row_nx[OFF_BG +: NUM_COLS] = bot_mask & {NUM_COLS{colour_in[1]}};
    row_nx[OFF_BB +: NUM_COLS] = bot_mask & {NUM_COLS{colour_in[2]}};
`ifdef LED_PATTERN_DEBUG_EN
    if (mode_active == MODE_DEBUG_ADDR) begin
      row_nx = '0;
      row_nx[OFF_TR +: NUM_COLS] = NUM_COLS'(addr);
      row_nx[OFF_BR +: NUM_COLS] = NUM_COLS'(addr) | {1'b1, {(NUM_COLS-1){1'b0}}};
    end
`endif
  end

  assign row_out         = row;
  assign row_valid_out   = (state == ST_PRESENT);
  assign row_address_out = addr;
  assign frame_start_out = transfer && (addr == '0);
  assign mode_active_out = mode_active;

endmodule

// File: tb/tb_led_pattern_gen_p.sv
// Bench for led_pattern_gen_p (8 columns, 16 row pairs, effect tick every 50 cycles).
module tb_led_pattern_gen_p;

  localparam int NC = 8;
  localparam int NR = 16;
  localparam int ET = 50;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [2:0]    colour = 3'd0;
  logic [2:0]    mode_in = 3'd0;
  logic          ready = 1'b0;
  logic [6*NC-1:0] row_out;
  logic          row_valid;
  logic [3:0]    row_addr;
  logic          frame_start;
  logic [2:0]    mode_active;

  int n_pass = 0;
  int n_total = 0;

  led_pattern_gen_p #(
    .SYS_CLK_FREQ  (100_000_000),
    .NUM_COLS      (NC),
    .NUM_ROW_PAIRS (NR),
    .EFFECT_TIMER  (ET)
  ) dut (
    .clk_in          (clk),
    .n_reset_in      (n_reset),
    .colour_in       (colour),
    .mode_in         (mode_in),
    .row_out         (row_out),
    .row_valid_out   (row_valid),
    .row_ready_in    (ready),
    .row_address_out (row_addr),
    .frame_start_out (frame_start),
    .mode_active_out (mode_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Reference picture: each pixel decided directly from the mode rules.
  function automatic logic [47:0] exp_render(input logic [2:0] m, input int a, input logic [2:0] col,
                                             input int cp, input int rp, input bit ph);
    logic [47:0] r;
    bit lt, lb;
    r = '0;
`ifdef LED_PATTERN_DEBUG_EN
    if (m == 3'd7) begin
      r[7:0]   = 8'(a);
      r[31:24] = 8'(a) | 8'h80;
      return r;
    end
`endif
    for (int c = 0; c < NC; c++) begin
      case (m)
        3'd1:    lt = 1'b1;
        3'd2:    lt = (c == cp);
        3'd3:    lt = (a == rp);
        3'd4:    lt = ((c % 2) ^ (a % 2) ^ ph) != 0;
        default: lt = 1'b0;
      endcase
      lb = (m == 3'd4) ? !lt : lt;
      for (int k = 0; k < 3; k++) begin
        r[k*NC + c]     = lt & col[k];
        r[(3+k)*NC + c] = lb & col[k];
      end
    end
    return r;
  endfunction

  // Behavioural model: gap = non-valid cycles left before the next row is shown.
  int          m_gap = 2, m_addr = 0, m_col = 0, m_rowp = 0, m_edges = 0;
  bit          m_phase = 0, m_pend = 0;
  logic [2:0]  m_mode = 3'd0, m_last_mode = 3'd0;
  logic [47:0] m_row = '0;

  initial forever begin
    bit tick_now;
    @(posedge clk);
    if (!n_reset) begin
      m_gap = 2; m_addr = 0; m_col = 0; m_rowp = 0; m_edges = 0;
      m_phase = 0; m_pend = 0; m_mode = 3'd0; m_row = '0;
    end else begin
      m_edges++;
      tick_now = (m_edges % ET) == 0;
      if (m_gap == 0) begin
        if (ready) begin
          m_gap  = (m_addr == NR - 1) ? 2 : 1;
          m_addr = (m_addr + 1) % NR;
        end
      end else if (m_gap == 2) begin
        if (m_last_mode != m_mode) begin
          m_mode = m_last_mode; m_col = 0; m_rowp = 0; m_phase = 0;
        end else if (m_pend) begin
          m_col = (m_col + 1) % NC; m_rowp = (m_rowp + 1) % NR; m_phase = !m_phase;
        end
        m_pend = 0;
        m_gap  = 1;
      end else begin
        m_row = exp_render(m_mode, m_addr, colour, m_col, m_rowp, m_phase);
        m_gap = 0;
      end
      if (tick_now) m_pend = 1;
    end
    m_last_mode = mode_in;
  end

  initial forever begin
    @(negedge clk);
    if (!n_reset) begin
      chk("rst_valid", 64'(row_valid), 64'(0));
      chk("rst_row", 64'(row_out), 64'(0));
      chk("rst_addr", 64'(row_addr), 64'(0));
      chk("rst_frame_start", 64'(frame_start), 64'(0));
      chk("rst_mode", 64'(mode_active), 64'(0));
    end else begin
      chk("mon_valid", 64'(row_valid), 64'(m_gap == 0));
      chk("mon_mode", 64'(mode_active), 64'(m_mode));
      chk("mon_frame_start", 64'(frame_start), 64'(m_gap == 0 && ready && m_addr == 0));
      if (m_gap == 0) begin
        chk("mon_addr", 64'(row_addr), 64'(m_addr));
        chk("mon_row", 64'(row_out), 64'(m_row));
      end
    end
  end

  task automatic do_reset(input logic [2:0] m, input logic [2:0] c);
    @(posedge clk); #1;
    n_reset = 1'b0; mode_in = m; colour = c; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
  endtask

  task automatic wait_row(input int target, input string name);
    bit found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (row_valid && row_addr == 4'(target)) begin found = 1; break; end
    end
    chk(name, 64'(found), 64'(1));
  endtask

  typedef struct {
    string       name;
    logic [2:0]  mode;
    logic [2:0]  colour;
    int          addr;
    logic [47:0] row;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int fs_cnt, rows, prev, col;
    bit saw_wrap, found;

    tbl[0] = '{"v_solid",    3'd1, 3'b101, 3, 48'hFF00FF_FF00FF};
    tbl[1] = '{"v_off",      3'd0, 3'b111, 2, 48'h000000_000000};
    tbl[2] = '{"v_check_a0", 3'd4, 3'b111, 0, 48'h555555_AAAAAA};
    tbl[3] = '{"v_check_a1", 3'd4, 3'b010, 1, 48'h00AA00_005500};
    tbl[4] = '{"v_scanv_on", 3'd3, 3'b001, 0, 48'h0000FF_0000FF};
    tbl[5] = '{"v_scanv_off",3'd3, 3'b001, 1, 48'h000000_000000};
    tbl[6] = '{"v_scanh",    3'd2, 3'b100, 4, 48'h010000_010000};
    tbl[7] = '{"v_mode5",    3'd5, 3'b111, 3, 48'h000000_000000};
    tbl[8] = '{"v_mode6",    3'd6, 3'b111, 7, 48'h000000_000000};
`ifdef LED_PATTERN_DEBUG_EN
    tbl[9] = '{"v_debug",    3'd7, 3'b111, 6, 48'h000086_000006};
`else
    tbl[9] = '{"v_debug",    3'd7, 3'b111, 6, 48'h000000_000000};
`endif

    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;

    foreach (tbl[i]) begin
      do_reset(tbl[i].mode, tbl[i].colour);
      wait_row(tbl[i].addr, {tbl[i].name, "_wait"});
      chk(tbl[i].name, 64'(row_out), 64'(tbl[i].row));
    end

    // SOLID frame: 16 rows, addresses in order, one frame_start per 33-cycle frame.
    do_reset(3'd1, 3'b101);
    wait_row(0, "s1_wait");
    fs_cnt = 0; rows = 0;
    for (int t = 0; t < 33; t++) begin
      if (t > 0) @(negedge clk);
      if (frame_start) fs_cnt++;
      if (row_valid) begin
        chk("s1_addr", 64'(row_addr), 64'(rows));
        chk("s1_row", 64'(row_out), 64'h0000_FF00FF_FF00FF);
        rows++;
      end
    end
    chk("s1_rows", 64'(rows), 64'(16));
    chk("s1_frame_start", 64'(fs_cnt), 64'(1));

    // Back-pressure: row 3 held for 10 cycles, transfer on first ready.
    wait_row(3, "s2_wait");
    #1 ready = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("s2_hold_valid", 64'(row_valid), 64'(1));
      chk("s2_hold_addr", 64'(row_addr), 64'(3));
      chk("s2_hold_row", 64'(row_out), 64'h0000_FF00FF_FF00FF);
    end
    #1 ready = 1'b1;
    @(negedge clk);
    chk("s2_xfer_valid", 64'(row_valid), 64'(0));
    chk("s2_xfer_addr", 64'(row_addr), 64'(4));

    // Mode change mid-frame only takes effect at the next frame.
    wait_row(5, "s3_wait5");
    #1 mode_in = 3'd2;
    wait_row(15, "s3_wait15");
    chk("s3_row15_solid", 64'(row_out), 64'h0000_FF00FF_FF00FF);
    wait_row(0, "s3_wait0");
    chk("s3_row0_scanh", 64'(row_out), 64'h0000_010001_010001);
    chk("s3_mode", 64'(mode_active), 64'(2));

    // Lit column advances by at most one per frame and wraps 7 -> 0.
    #1 colour = 3'b001;
    prev = -1; saw_wrap = 0;
    for (int f = 0; f < 30; f++) begin
      wait_row(0, "s4_wait");
      col = -1;
      for (int k = 0; k < NC; k++) if (row_out[k]) col = k;
      chk("s4_onehot", 64'($countones(row_out[7:0])), 64'(1));
      if (prev >= 0) begin
        chk("s4_step", 64'(col == prev || col == (prev + 1) % NC), 64'(1));
        if (prev == NC - 1 && col == 0) saw_wrap = 1;
      end
      prev = col;
    end
    chk("s4_wrap", 64'(saw_wrap), 64'(1));

    // Reset during PRESENT at address 9.
    #1 mode_in = 3'd1; colour = 3'b111;
    wait_row(9, "s5_wait");
    #1 n_reset = 1'b0;
    #1;
    chk("s5_valid_drop", 64'(row_valid), 64'(0));
    chk("s5_addr_clr", 64'(row_addr), 64'(0));
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (row_valid) begin found = 1; break; end
    end
    chk("s5_valid_back", 64'(found), 64'(1));
    chk("s5_first_addr", 64'(row_addr), 64'(0));

    // Randomised run against the model.
    for (int t = 0; t < 4000; t++) begin
      @(posedge clk); #1;
      ready  = ($urandom_range(0, 3) != 0);
      colour = 3'($urandom);
      if ($urandom_range(0, 149) == 0) mode_in = 3'($urandom);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen_p.md
LED_PATTERN_GEN_P -- requirements
Module: led_pattern_gen_p

Interface
REQ-001 Parameter SYS_CLK_FREQ, 100_000_000, system clock frequency in Hz (informational; no timing is derived from it).
REQ-002 Parameter NUM_COLS, 64, pixels per half-row; legal values are 8 to 128.
REQ-003 Parameter NUM_ROW_PAIRS, 16, row addresses per frame; must be a power of two, 2 to 32; ADDR_W = clog2(NUM_ROW_PAIRS).
REQ-004 Parameter EFFECT_TIMER, 1_000_000, clock cycles between effect steps.
REQ-005 Port clk_in, input, 1: the single clock.
REQ-006 Port n_reset_in, input, 1: asynchronous active-low reset.
REQ-007 Port colour_in, input, 3: {blue, green, red} lit-pixel colour, sampled when the row is built.
REQ-008 Port mode_in, input, 3: requested mode.
REQ-009 Port row_out, output, 6*NUM_COLS: lanes from LSB are top.red, top.green, top.blue, bot.red, bot.green, bot.blue; bit i of each lane is column i.
REQ-010 Port row_valid_out, output, 1: row_out and row_address_out are valid.
REQ-011 Port row_ready_in, input, 1: the consumer accepts the row.
REQ-012 Port row_address_out, output, ADDR_W: row-pair address of row_out.
REQ-013 Port frame_start_out, output, 1: one-cycle pulse on the transfer of address 0.
REQ-014 Port mode_active_out, output, 3: the mode currently being rendered.

Function
REQ-015 Modes: 0 OFF (all zero), 1 SOLID (all pixels colour_in), 2 SCAN_H, 3 SCAN_V, 4 CHECKER, 7 DEBUG_ADDR; codes 5 and 6 render as OFF.
REQ-016 SCAN_H: only column col_pos is lit, in both halves and in every row.
REQ-017 SCAN_V: all columns of both halves are lit only when address == row_pos.
REQ-018 CHECKER: pixel (c, a) is lit when c[0] ^ a[0] ^ phase is 1; the bottom half uses the inverse of the top half.
REQ-019 DEBUG_ADDR: top.red = address zero-extended; bot.red = address with bit NUM_COLS-1 set; all other lanes are 0.
REQ-020 FSM states are IDLE, LOAD, PRESENT and FRAME_END.
REQ-021 FSM transitions:
- IDLE to LOAD in the first cycle after reset release.
- LOAD registers row_out and moves to PRESENT.
- PRESENT holds until a transfer (valid && ready); on transfer it moves to LOAD, or to FRAME_END if address == NUM_ROW_PAIRS-1.
- FRAME_END moves to LOAD.
REQ-022 row_valid_out is 1 only in PRESENT.
REQ-023 row_out and row_address_out are stable while valid && !ready.
REQ-024 row_ready_in is ignored outside PRESENT.
REQ-025 The address increments on each transfer and wraps from NUM_ROW_PAIRS-1 to 0.
REQ-026 Exactly one non-valid (LOAD) cycle separates consecutive rows within a frame; two separate them across a frame boundary.
REQ-027 mode_in is sampled every cycle into mode_pending; mode_active changes only in FRAME_END or IDLE, so no frame mixes two modes.
REQ-028 A sticky tick_pending flag is set by the effect timer and consumed in FRAME_END. On consumption: col_pos increments and wraps at NUM_COLS-1; row_pos increments and wraps at NUM_ROW_PAIRS-1; phase toggles.
REQ-029 A tick and its consumption in the same cycle leave tick_pending set.
REQ-030 A change of mode_active clears col_pos, row_pos and phase, and the address is 0.

Reset
REQ-031 Reset asynchronously forces:
- row_out = 0, row_valid_out = 0, row_address_out = 0, frame_start_out = 0;
- mode_active_out = 0; state = IDLE;
- the timer, tick_pending, col_pos, row_pos and phase cleared.
REQ-032 Reset during PRESENT drops row_valid_out in the same cycle with no partial transfer; the first valid row after release is address 0.

Configuration
REQ-033 With LED_PATTERN_DEBUG_EN defined, mode 7 renders DEBUG_ADDR.
REQ-034 Without LED_PATTERN_DEBUG_EN, mode 7 renders OFF and the DEBUG_ADDR logic is absent.

Structure
REQ-035 led_display_pkg holds:
- the mode code constants;
- the lane index constants (LANE_TOP_RED to LANE_BOT_BLUE);
- a lane-offset function.
REQ-036 Sub-module led_effect_timer (parameter EFFECT_TIMER) produces a one-cycle tick every EFFECT_TIMER cycles.

Verification
REQ-037 Scenario 1: SOLID, colour 3'b101, ready held at 1 -> 16 rows, each with top.red = top.blue = all ones and green = 0; addresses 0 to 15; frame_start_out pulses once per frame.
REQ-038 Scenario 2: ready held at 0 for 10 cycles in PRESENT -> row_out and address unchanged; the transfer occurs on the first cycle ready is 1.
REQ-039 Scenario 3: mode_in changes from 1 to 2 mid-frame at address 5 -> rows 5 to 15 remain SOLID; the next frame starts at address 0 with only column 0 lit.
REQ-040 Scenario 4: SCAN_H with EFFECT_TIMER = 50, NUM_COLS = 8 -> the lit column advances once per frame boundary after a tick and wraps from 7 to 0.
REQ-041 Scenario 5: reset asserted while valid = 1 at address 9 -> valid = 0 immediately; after release the first row is address 0.
REQ-042 Scenario 6: mode 7, with and without LED_PATTERN_DEBUG_EN -> top.red equals the address when defined; all zero when not.
